// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronises rx, finds start edges, majority-votes each bit
// around mid-bit, and hands completed frames to a one-entry valid/ready buffer with status flags.
module uart_rx_os #(
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned OVERSAMPLE  = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned     OsW      = $clog2(OVERSAMPLE);
    localparam logic [OsW-1:0]  OsLast   = OsW'(OVERSAMPLE - 1);
    localparam logic [OsW-1:0]  SmpA     = OsW'(OVERSAMPLE / 2 - 1);
    localparam logic [OsW-1:0]  SmpB     = OsW'(OVERSAMPLE / 2);
    localparam logic [OsW-1:0]  SmpC     = OsW'(OVERSAMPLE / 2 + 1);
    localparam logic [3:0]      DataLast = 4'(DATA_BITS - 1);
    localparam logic [3:0]      StopLast = 4'(STOP_BITS - 1);
    localparam logic            OddPar   = (PARITY == 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e                 state_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_prev_q;
    logic [OsW-1:0]         os_cnt_q;
    logic [3:0]             bit_cnt_q;
    logic                   smp_a_q;
    logic                   smp_b_q;
    logic [DATA_BITS-1:0]   shift_q;
    logic                   zero_q;
    logic                   par_err_q;

    logic                   decide;
    logic                   wrap;
    logic                   bit_val;
    logic                   stop_done;

    assign rxs     = sync_q[SYNC_STAGES-1];
    assign decide  = os_tick && (os_cnt_q == SmpC);
    assign wrap    = os_tick && (os_cnt_q == OsLast);
    // Third vote is the live sample taken on the deciding tick.
    assign bit_val = (smp_a_q & smp_b_q) | (smp_a_q & rxs) | (smp_b_q & rxs);
    // A low stop bit ends the frame at once; otherwise the last stop bit ends it.
    assign stop_done = (state_q == StStop) && decide && (!bit_val || (bit_cnt_q == StopLast));
    assign busy      = (state_q != StIdle);

    // rx synchroniser plus previous-value flop for start-edge detection; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
            rxs_prev_q <= rxs;
        end
    end

    // Frame FSM with oversample counter, bit sampling, data shift and parity/zero tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            os_cnt_q  <= '0;
            bit_cnt_q <= '0;
            smp_a_q   <= 1'b0;
            smp_b_q   <= 1'b0;
            shift_q   <= '0;
            zero_q    <= 1'b1;
            par_err_q <= 1'b0;
        end else if (state_q == StIdle) begin
            // A break leaves rxs low, so no edge is seen until the line has returned high.
            if (rxs_prev_q && !rxs) begin
                state_q  <= StStart;
                os_cnt_q <= '0;
            end
        end else begin
            if (os_tick) begin
                os_cnt_q <= (os_cnt_q == OsLast) ? '0 : os_cnt_q + OsW'(1);
                if (os_cnt_q == SmpA) smp_a_q <= rxs;
                if (os_cnt_q == SmpB) smp_b_q <= rxs;
            end
            case (state_q)
                StStart: begin
                    if (decide && bit_val) begin
                        state_q <= StIdle;
                    end else if (wrap) begin
                        state_q   <= StData;
                        bit_cnt_q <= '0;
                        zero_q    <= 1'b1;
                        par_err_q <= 1'b0;
                    end
                end
                StData: begin
                    if (decide) begin
                        shift_q <= {bit_val, shift_q[DATA_BITS-1:1]};
                        zero_q  <= zero_q & ~bit_val;
                    end
                    if (wrap) begin
                        if (bit_cnt_q == DataLast) begin
                            bit_cnt_q <= '0;
                            state_q   <= (PARITY != 0) ? StParity : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end
                    end
                end
                StParity: begin
                    if (decide) begin
                        par_err_q <= (^shift_q) ^ bit_val ^ OddPar;
                        zero_q    <= zero_q & ~bit_val;
                    end
                    if (wrap) begin
                        state_q <= StStop;
                    end
                end
                StStop: begin
                    if (stop_done) begin
                        state_q <= StIdle;
                    end else if (decide) begin
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // One-entry output buffer: load on completion if free or being drained, else flag overrun.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data     <= '0;
            m_valid    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            break_det  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (stop_done) begin
                if (!m_valid || m_ready) begin
                    m_data     <= shift_q;
                    m_valid    <= 1'b1;
                    parity_err <= par_err_q;
                    frame_err  <= ~bit_val;
                    break_det  <= ~bit_val & zero_q;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule
